// File: rtl/stat_engine.sv
// Pet-stat manager: NUM_STATS saturating counters that grow on prescaler ticks
// (stat picked by an LFSR) and shrink on care requests over valid/ready.
module stat_engine #(
   parameter int          NUM_STATS  = 6,
   parameter int          STAT_W     = 4,
   parameter int          TICK_DIV   = 10_000_000,
   parameter int          INIT_LEVEL = 0,
   parameter int          CRIT_LEVEL = 12,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         IDX_W      = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          care_valid,
   output logic                          care_ready,
   input  logic [IDX_W-1:0]              care_id,
   input  logic [STAT_W-1:0]             care_amt,
   output logic [NUM_STATS*STAT_W-1:0]   stats,
   output logic                          tick,
   output logic [NUM_STATS-1:0]          critical,
   output logic                          any_critical,
   output logic                          care_err
);

   localparam int                CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
   localparam logic [STAT_W-1:0] INIT_V    = STAT_W'(INIT_LEVEL);
   localparam logic [STAT_W:0]   CRIT_V    = (STAT_W+1)'(CRIT_LEVEL);
   localparam logic [IDX_W:0]    NUM_C     = (IDX_W+1)'(NUM_STATS);
   localparam logic [15:0]       LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_APPLY = 2'd2} state_e;

   state_e                    state_q, state_d;
   logic [2:0]                rej_q, rej_d;
   logic [IDX_W-1:0]          sel_q, sel_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      tick_q, tick_d;
   logic [15:0]               lfsr_q, lfsr_d;
   logic                      ready_q;
   logic                      err_q, err_d;
   logic [STAT_W-1:0]         stat_q [NUM_STATS];
   logic [STAT_W-1:0]         stat_d [NUM_STATS];
   logic signed [STAT_W+1:0]  net_s  [NUM_STATS];
   logic                      grow_s;
   logic                      care_fire_s;
   logic                      care_bad_s;
   logic [IDX_W-1:0]          cand_s;

   assign care_fire_s = care_valid && ready_q;
   assign care_bad_s  = ({1'b0, care_id} >= NUM_C);
   assign cand_s      = lfsr_q[IDX_W-1:0];

   // Prescaler: wraps at TICK_DIV-1 and flags a tick for the following cycle
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Galois LFSR x^16+x^14+x^13+x^11+1, free-running
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   end

   // Growth FSM next state: draw an in-range index, give up to stat 0 on the fifth try
   always_comb begin
      state_d = state_q;
      rej_d   = rej_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE: begin
            if (tick_q) begin
               state_d = S_DRAW;
               rej_d   = 3'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRAW: begin
            if ({1'b0, cand_s} < NUM_C) begin
               sel_d   = cand_s;
               state_d = S_APPLY;
            end else if (rej_q == 3'd4) begin
               sel_d   = '0;
               state_d = S_APPLY;
            end else begin
               rej_d = rej_q + 3'd1;
            end
         end
         S_APPLY: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Growth FSM output
   always_comb begin
      case (state_q)
         S_APPLY: grow_s = 1'b1;
         default: grow_s = 1'b0;
      endcase
   end

   // Per-stat update; growth and care on the same stat merge before clamping
   always_comb begin
      err_d = care_fire_s && care_bad_s;
      for (int i = 0; i < NUM_STATS; i++) begin
         net_s[i] = {2'b00, stat_q[i]};
         if (grow_s && (sel_q == IDX_W'(i))) begin
            net_s[i] = net_s[i] + (STAT_W+2)'(1);
         end else begin
            net_s[i] = net_s[i];
         end
         if (care_fire_s && !care_bad_s && (care_id == IDX_W'(i))) begin
            net_s[i] = net_s[i] - {2'b00, care_amt};
         end else begin
            net_s[i] = net_s[i];
         end
         if (net_s[i][STAT_W+1]) begin
            stat_d[i] = '0;
         end else if (net_s[i][STAT_W]) begin
            stat_d[i] = '1;
         end else begin
            stat_d[i] = net_s[i][STAT_W-1:0];
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rej_q   <= 3'd0;
         sel_q   <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= INIT_V;
      end else begin
         state_q <= state_d;
         rej_q   <= rej_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         lfsr_q  <= lfsr_d;
         ready_q <= 1'b1;
         err_q   <= err_d;
         for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= stat_d[i];
      end
   end

   // Flat stat vector and critical flags straight from the stat registers
   always_comb begin
      stats    = '0;
      critical = '0;
      for (int i = 0; i < NUM_STATS; i++) begin
         stats[i*STAT_W +: STAT_W] = stat_q[i];
         critical[i]               = ({1'b0, stat_q[i]} >= CRIT_V);
      end
   end

   assign any_critical = |critical;
   assign tick         = tick_q;
   assign care_err     = err_q;
   assign care_ready   = ready_q;

endmodule
